mitchell_etm_mult_pipe: RTL

// Pipelined, parametrised Mitchell log-domain unsigned multiplier with run-time programmable error-correction table.

---
 rtl/mitchell_etm_mult_pipe.sv | 265 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/mitchell_etm_mult_pipe.sv
// -----------------------------------------------------------------------------
// mitchell_etm_mult_pipe
//
// Purpose
//   This is a three-stage pipelined unsigned multiplier that uses Mitchell's
//   logarithmic approximation. A run-time loadable 2-D table corrects the
//   approximation error.
//   - The top IDX_BITS fraction bits of each operand's log fraction select a
//     table entry. Operand a selects the row and operand b selects the column.
//   - The entry is added to the sum of the two log fractions before the
//     antilog step.
//   The block sits between the operand producers and the ETM accumulation
//   datapath, and uses a valid/ready handshake on both sides.
//
// Configuration macro
//   MITCHELL_CORR_EN
//     Defined   : the correction table, its write port and the correction
//                 add are built.
//     Undefined : no table storage is built and the correction term is zero,
//                 so the block is a pure Mitchell multiplier. The cfg_* ports
//                 stay on the interface but are ignored. Latency and
//                 handshake behaviour are the same in both builds.
//
// Parameters
//   WIDTH     operand width (FRAC = WIDTH-1 fraction bits), WIDTH >= 2
//   IDX_BITS  fraction MSBs per operand used as table index (<= WIDTH-1)
//   CORR_W    width of an unsigned correction entry, LSB = 2^-FRAC
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset; flushes the pipe and
//                   clears the table
//   in_valid   in   operand pair valid
//   in_ready   out  operands accepted this cycle (= pipeline advance)
//   a, b       in   unsigned operands, WIDTH bits
//   out_valid  out  product valid
//   out_ready  in   consumer accepts product
//   p          out  approximate product, 2*WIDTH bits
//   cfg_we     in   table write strobe
//   cfg_addr   in   table address {row(a), col(b)}
//   cfg_wdata  in   table entry
//
// Timing
//   A pair accepted in cycle n presents out_valid in cycle n+3.
//   Throughput is one pair per cycle.
//   Every stage moves only when the output register is free or is being
//   consumed. Bubbles are kept in place during a stall, so ordering is
//   exact and no product is dropped or duplicated.
// -----------------------------------------------------------------------------
module mitchell_etm_mult_pipe #(
    parameter int WIDTH    = 8,
    parameter int IDX_BITS = 3,
    parameter int CORR_W   = 10
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WIDTH-1:0]        a,
    input  logic [WIDTH-1:0]        b,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [2*WIDTH-1:0]      p,
    input  logic                    cfg_we,
    input  logic [2*IDX_BITS-1:0]   cfg_addr,
    input  logic [CORR_W-1:0]       cfg_wdata
);

    localparam int FRAC    = WIDTH - 1;
    // Leading-one position of one operand: 0 .. WIDTH-1.
    localparam int KAW     = $clog2(WIDTH);
    // Combined exponent including the carry from the mantissa: 0 .. 2*WIDTH-1.
    localparam int KW      = $clog2(2 * WIDTH);
    // The raw sum can exceed the FRAC+2-bit result.
    // Two guard bits above the widest addend keep the saturation compare exact.
    localparam int SUMW    = ((FRAC + 1 > CORR_W) ? FRAC + 1 : CORR_W) + 2;
    localparam int SAT_MAX = (1 << (FRAC + 1)) - 1;
    // Wide enough for (mant << k) before the final >> FRAC.
    localparam int PW      = FRAC + 2 * WIDTH;

    // -------------------------------------------------------------------------
    // Handshake: a single advance enable drives the whole pipe.
    // -------------------------------------------------------------------------
    logic adv;
    logic out_valid_q;

    assign adv       = out_ready | ~out_valid_q;
    assign in_ready  = adv;
    assign out_valid = out_valid_q;

    // -------------------------------------------------------------------------
    // S1 (combinational on the inputs):
    //   - leading-one position k of each operand
    //   - normalised fraction x = (op << (FRAC-k)) with the hidden one dropped
    // A zero operand yields k=0 and x=0. Its product is forced to zero
    // later, so those values are don't-care.
    // -------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_lod
            logic [WIDTH-1:0] opnd;
            logic [KAW-1:0]   k;
            logic [FRAC-1:0]  x;

            assign opnd = (gi == 0) ? a : b;

            always_comb begin
                k = '0;
                for (int i = 0; i < WIDTH; i++) begin
                    if (opnd[i]) begin
                        k = KAW'(i);
                    end
                end
            end

            // The cast truncates the shifted leading one away, leaving the fraction.
            assign x = FRAC'(opnd << (FRAC - int'(k)));
        end
    endgenerate

    logic             z1_d;
    logic [KAW-1:0]   ka1_d;
    logic [KAW-1:0]   kb1_d;
    logic [FRAC-1:0]  xa1_d;
    logic [FRAC-1:0]  xb1_d;

    assign z1_d  = (a == '0) | (b == '0);
    assign ka1_d = g_lod[0].k;
    assign kb1_d = g_lod[1].k;
    assign xa1_d = g_lod[0].x;
    assign xb1_d = g_lod[1].x;

    logic             v1_q;
    logic             z1_q;
    logic [KAW-1:0]   ka1_q;
    logic [KAW-1:0]   kb1_q;
    logic [FRAC-1:0]  xa1_q;
    logic [FRAC-1:0]  xb1_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q  <= 1'b0;
            z1_q  <= 1'b0;
            ka1_q <= '0;
            kb1_q <= '0;
            xa1_q <= '0;
            xb1_q <= '0;
        end else if (adv) begin
            v1_q  <= in_valid;
            z1_q  <= z1_d;
            ka1_q <= ka1_d;
            kb1_q <= kb1_d;
            xa1_q <= xa1_d;
            xb1_q <= xb1_d;
        end
    end

    // -------------------------------------------------------------------------
    // S2: correction lookup and saturating log-fraction sum.
    // The table is read combinationally from its current contents.
    // - A write in the same cycle lands at the clock edge, so the sample
    //   advancing at that edge sees the old entry.
    // - The looked-up correction is folded into s and frozen in the S2
    //   register, so a stall later cannot change it.
    // -------------------------------------------------------------------------
    logic [CORR_W-1:0] corr;

`ifdef MITCHELL_CORR_EN
    localparam int NENT = 1 << (2 * IDX_BITS);

    logic [CORR_W-1:0]   tbl_q [NENT];
    logic [IDX_BITS-1:0] row;
    logic [IDX_BITS-1:0] col;

    // Register array rather than block RAM: every entry must clear on reset,
    // so the table restarts as plain Mitchell.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NENT; i++) begin
                tbl_q[i] <= '0;
            end
        end else if (cfg_we) begin
            tbl_q[cfg_addr] <= cfg_wdata;
        end
    end

    assign row  = xa1_q[FRAC-1 -: IDX_BITS];
    assign col  = xb1_q[FRAC-1 -: IDX_BITS];
    assign corr = tbl_q[{row, col}];
`else
    logic cfg_unused;

    assign cfg_unused = ^{cfg_we, cfg_addr, cfg_wdata};
    assign corr       = '0;
`endif

    logic [SUMW-1:0] sum_raw;
    logic [FRAC:0]   s2_d;
    logic [KW-1:0]   k2_d;

    assign sum_raw = SUMW'(xa1_q) + SUMW'(xb1_q) + SUMW'(corr);
    // After saturation s fits in FRAC+1 bits; the FRAC+2-bit sum never
    // needs its top bit downstream.
    assign s2_d    = (sum_raw > SUMW'(SAT_MAX)) ? {(FRAC + 1){1'b1}} : sum_raw[FRAC:0];
    assign k2_d    = KW'(ka1_q) + KW'(kb1_q);

    logic             v2_q;
    logic             z2_q;
    logic [KW-1:0]    k2_q;
    logic [FRAC:0]    s2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2_q <= 1'b0;
            z2_q <= 1'b0;
            k2_q <= '0;
            s2_q <= '0;
        end else if (adv) begin
            v2_q <= v1_q;
            z2_q <= z1_q;
            k2_q <= k2_d;
            s2_q <= s2_d;
        end
    end

    // -------------------------------------------------------------------------
    // S3: antilog.
    // - If s < 2^FRAC, restore the hidden one.
    // - Otherwise the sum has already carried into the integer bit.
    //   That bit becomes the hidden one, and the exponent grows by one.
    // -------------------------------------------------------------------------
    logic [FRAC:0]        mant;
    logic [KW-1:0]        kf;
    logic [2*WIDTH-1:0]   p_d;

    always_comb begin
        mant = '0;
        kf   = '0;
        p_d  = '0;
        if (s2_q[FRAC]) begin
            mant = s2_q;
            kf   = k2_q + KW'(1);
        end else begin
            mant = {1'b1, s2_q[FRAC-1:0]};
            kf   = k2_q;
        end
        if (!z2_q) begin
            p_d = (2 * WIDTH)'((PW'(mant) << kf) >> FRAC);
        end
    end

    logic [2*WIDTH-1:0] p_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            p_q         <= '0;
        end else if (adv) begin
            out_valid_q <= v2_q;
            p_q         <= p_d;
        end
    end

    assign p = p_q;

endmodule
